alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares the single 16-bit CLA ALU (claAdde16b) between two requesters: port 0 is the main datapath and port 1 is the branch/PC-address unit. Each request is accepted with a req/done handshake, and conflicts are resolved round-robin. The block drives the ALU inputs from registers, captures the ALU result and flags, and returns them to the granted requester. It sits between the control unit and the ALU in the multi-cycle processor.

Parameters:
WIDTH, 16, operand/result width (must match the ALU).
OPW, 3, ALU op-code width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req0  in  1  requester 0 request; held until done0.
a0  in  WIDTH  requester 0 operand A.
b0  in  WIDTH  requester 0 operand B.
op0  in  OPW  requester 0 ALU op.
req1  in  1  requester 1 request; held until done1.
a1  in  WIDTH  requester 1 operand A.
b1  in  WIDTH  requester 1 operand B.
op1  in  OPW  requester 1 ALU op.
done0  out  1  one-cycle pulse: result valid for requester 0.
done1  out  1  one-cycle pulse: result valid for requester 1.
r  out  WIDTH  registered result (shared; qualify with doneN).
c_out  out  1  registered carry-out.
overflow  out  1  registered signed overflow.
zero  out  1  registered zero flag.
err  out  1  valid with doneN; 1 means illegal op, no ALU operation was performed.
busy  out  1  1 in EXEC and DONE states.
alu_a  out  WIDTH  to ALU a.
alu_b  out  WIDTH  to ALU b.
alu_op  out  OPW  to ALU op.
alu_r  in  WIDTH  from ALU r.
alu_c_out  in  1  from ALU c_out.
alu_overflow  in  1  from ALU overflow.
alu_zero  in  1  from ALU zero.

Behaviour:
- Legal ops: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. All others are illegal.
- Reset (async): state IDLE; all outputs 0 (alu_a/alu_b/alu_op, r, flags, err, done0/1, busy); priority pointer set to requester 0.
- FSM states:
  - IDLE: if no req, stay in IDLE. Otherwise pick a winner.
    - One requester active: it wins.
    - Both active: the pointer side wins.
    - On the winning edge: latch grant id, register alu_a/alu_b/alu_op from the winner, latch err_pending = illegal(op). Go to EXEC.
  - EXEC: the ALU evaluates combinationally from the registered inputs.
    - At the clock edge, capture alu_r/alu_c_out/alu_overflow/alu_zero into r/c_out/overflow/zero.
    - If err_pending: capture r=0 and all flags=0 instead, and set err=1.
    - Go to DONE.
  - DONE: assert done<grant>=1 for exactly this cycle. r/flags/err hold their values.
    - Pointer moves to the non-granted requester.
    - Unconditionally go to IDLE; req is not sampled in DONE.
- Latency: req sampled at edge E → done high in cycle E+2 → next grant no earlier than edge E+3. Throughput is one op per 3 cycles.
- Handshake:
  - The requester holds operands stable while req=1 and deasserts req in the cycle after done.
  - A req still high in IDLE counts as a new request.
- r/flags/err remain valid after DONE until the next EXEC capture. alu_* inputs hold between operations.
- Boundary conditions:
  - A req dropping during EXEC/DONE does not abort: done still pulses.
  - Operand changes after grant are ignored.
  - Reset mid-EXEC/DONE: immediate return to IDLE with no done pulse; the requester must re-request.
  - Simultaneous req0/req1 after a fresh reset: requester 0 wins first.
  - Back-to-back requests from a single requester are all granted to it; the pointer does not starve a lone requester.
- done0 and done1 are never high in the same cycle.

Decomposition:
- Package alu_arb_pkg:
  - Op constants OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111.
  - State encoding IDLE/EXEC/DONE.
  - Function is_legal_op.
- Sub-module alu_rr_pick2: combinational two-way round-robin picker. Inputs req0, req1, ptr; outputs valid, winner.
- The ALU stays external; the bench instantiates claAdde16b beside this block.

Test Plan:
- Reset, then req0 with a0=1, b0=2, op=010 → alu inputs registered at E, done0 in E+2, r=3, err=0, busy=1 during E+1..E+2.
- req0 and req1 raised in the same cycle: req0 {30000, 30000, ADD}, req1 {8, 4, SUB} → done0 first with overflow=1; then done1 three cycles later with r=4, zero=0.
- req1 alone three times back-to-back with {0, 8, SLT} → each returns r=1, and done0 never asserts.
- Both requesters held continuously → grants alternate 0, 1, 0, 1; operands 16'hFFFF AND 0 return r=0, zero=1.
- op0=3'b011 → done0 with err=1, r=0, all flags 0; the next legal op has err=0.
- Assert reset during EXEC of a req1 op → outputs 0 asynchronously and no done1; after release, re-request returns the correct result.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module  : alu_arb_pkg
// Brief   : Shared op-codes, FSM state encoding and op legality check for
//           the two-port ALU share arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the five op-codes the ALU implements
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rr_pick2.sv
// ============================================================================
// Module  : alu_rr_pick2
// Brief   : Combinational two-way round-robin picker. A lone requester always
//           wins; on a tie the side named by ptr wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic valid,
  output logic winner
);

  // Tie goes to ptr; otherwise whichever side is requesting
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? ptr : req1;
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module  : alu_share_arbiter
// Brief   : Time-shares one external 16-bit ALU between the main datapath
//           (port 0) and the branch/PC unit (port 1). Three-state FSM:
//           IDLE grants, EXEC captures the ALU result, DONE pulses doneN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [OPW-1:0]   op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [OPW-1:0]   op1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] r,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_c_out,
  input  logic             alu_overflow,
  input  logic             alu_zero
);

  state_e           state_q;
  logic             ptr_q;
  logic             grant_q;
  logic             err_pend_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] r_q;
  logic             c_q, ov_q, z_q, err_q;
  logic             done0_q, done1_q, busy_q;

  logic             pick_valid, pick_winner;
  logic [WIDTH-1:0] win_a_d, win_b_d;
  logic [OPW-1:0]   win_op_d;

  alu_rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Operand mux: route the winning requester's operands toward the ALU regs
  always_comb begin
    win_a_d  = pick_winner ? a1  : a0;
    win_b_d  = pick_winner ? b1  : b0;
    win_op_d = pick_winner ? op1 : op0;
  end

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      grant_q    <= 1'b0;
      err_pend_q <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      r_q        <= '0;
      c_q        <= 1'b0;
      ov_q       <= 1'b0;
      z_q        <= 1'b0;
      err_q      <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q    <= pick_winner;
            alu_a_q    <= win_a_d;
            alu_b_q    <= win_b_d;
            alu_op_q   <= win_op_d;
            err_pend_q <= ~is_legal_op(win_op_d[2:0]);
            busy_q     <= 1'b1;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Illegal ops report a cleared result rather than whatever the ALU
          // happens to produce for the unused encoding.
          if (err_pend_q) begin
            r_q   <= '0;
            c_q   <= 1'b0;
            ov_q  <= 1'b0;
            z_q   <= 1'b0;
            err_q <= 1'b1;
          end else begin
            r_q   <= alu_r;
            c_q   <= alu_c_out;
            ov_q  <= alu_overflow;
            z_q   <= alu_zero;
            err_q <= 1'b0;
          end
          done0_q <= ~grant_q;
          done1_q <= grant_q;
          state_q <= ST_EXEC == ST_EXEC ? ST_DONE : ST_IDLE;
        end
        ST_DONE: begin
          // Requests are not sampled here, so a lone requester always finds
          // the pointer irrelevant on its next tie-free grant.
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          ptr_q   <= ~grant_q;
          state_q <= ST_IDLE;
        end
        default: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign r        = r_q;
  assign c_out    = c_q;
  assign overflow = ov_q;
  assign zero     = z_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module  : tb_alu_share_arbiter
// Brief   : Directed self-checking bench for alu_share_arbiter with a small
//           behavioural stand-in for the 16-bit ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0]  op0 = '0, op1 = '0;
  logic        done0, done1, c_out, overflow, zero, err, busy;
  logic [15:0] r, alu_a, alu_b, alu_r;
  logic [2:0]  alu_op;
  logic        alu_c_out, alu_overflow, alu_zero;

  int tests = 0;
  int failed = 0;
  int done0_cnt = 0;
  int done1_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(16), .OPW(3)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .done0(done0), .done1(done1), .r(r), .c_out(c_out),
    .overflow(overflow), .zero(zero), .err(err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_c_out(alu_c_out), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero)
  );

  // Behavioural ALU: AND, OR, ADD, SUB, SLT
  logic [16:0] sum17;
  logic        sub_ov, add_ov;
  always_comb begin
    sum17        = '0;
    add_ov       = 1'b0;
    sub_ov       = 1'b0;
    alu_r        = '0;
    alu_c_out    = 1'b0;
    alu_overflow = 1'b0;
    if (alu_op[2]) sum17 = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
    else           sum17 = {1'b0, alu_a} + {1'b0, alu_b};
    add_ov = (alu_a[15] == alu_b[15]) && (sum17[15] != alu_a[15]);
    sub_ov = (alu_a[15] != alu_b[15]) && (sum17[15] != alu_a[15]);
    case (alu_op)
      3'b000: alu_r = alu_a & alu_b;
      3'b001: alu_r = alu_a | alu_b;
      3'b010: begin alu_r = sum17[15:0]; alu_c_out = sum17[16]; alu_overflow = add_ov; end
      3'b110: begin alu_r = sum17[15:0]; alu_c_out = sum17[16]; alu_overflow = sub_ov; end
      3'b111: alu_r = {15'd0, sum17[15] ^ sub_ov};
      default: alu_r = 16'hDEAD;
    endcase
    alu_zero = (alu_r == 16'd0);
  end

  // Pulse bookkeeping, sampled away from the active edge
  always @(negedge clk) begin
    if (done0) done0_cnt <= done0_cnt + 1;
    if (done1) done1_cnt <= done1_cnt + 1;
    if (done0 && done1) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step clocks until the chosen done pulses; n = cycles taken, bounded
  task automatic wait_done(input int which, output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if ((which == 0 && done0) || (which == 1 && done1)) begin
        n = k;
        return;
      end
    end
    tests++;
    failed++;
    $error("FAIL timeout_done%0d: observed no pulse expected pulse", which);
  endtask

  task automatic wait_any(output int which);
    which = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done0) begin which = 0; return; end
      if (done1) begin which = 1; return; end
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  int n, w, snap;

  initial begin
    // Reset state
    #1;
    check("rst_r",      {16'd0, r}, 32'd0);
    check("rst_flags",  {28'd0, c_out, overflow, zero, err}, 32'd0);
    check("rst_done",   {30'd0, done0, done1}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_alu_in", {13'd0, alu_op, alu_a}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single ADD on port 0 with cycle-exact latency
    a0 = 16'd1; b0 = 16'd2; op0 = 3'b010; req0 = 1'b1;
    @(posedge clk); #1;
    check("t1_alu_a",  {16'd0, alu_a}, 32'd1);
    check("t1_alu_b",  {16'd0, alu_b}, 32'd2);
    check("t1_alu_op", {29'd0, alu_op}, 32'd2);
    check("t1_busy_e1", {31'd0, busy}, 32'd1);
    check("t1_nodone", {30'd0, done0, done1}, 32'd0);
    @(posedge clk); #1;
    check("t1_done0",  {31'd0, done0}, 32'd1);
    check("t1_r",      {16'd0, r}, 32'd3);
    check("t1_err",    {31'd0, err}, 32'd0);
    check("t1_busy_e2", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    @(posedge clk); #1;
    check("t1_done_end", {31'd0, done0}, 32'd0);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_r_hold",   {16'd0, r}, 32'd3);

    // Simultaneous requests after fresh reset: port 0 first
    do_reset();
    a0 = 16'd30000; b0 = 16'd30000; op0 = 3'b010;
    a1 = 16'd8;     b1 = 16'd4;     op1 = 3'b110;
    req0 = 1'b1; req1 = 1'b1;
    wait_done(0, n);
    check("t2_lat0",  n, 32'd2);
    check("t2_r0",    {16'd0, r}, 32'hEA60);
    check("t2_ov0",   {31'd0, overflow}, 32'd1);
    check("t2_c0",    {31'd0, c_out}, 32'd0);
    check("t2_d1_lo", {31'd0, done1}, 32'd0);
    req0 = 1'b0;
    wait_done(1, n);
    check("t2_gap1",  n, 32'd3);
    check("t2_r1",    {16'd0, r}, 32'd4);
    check("t2_z1",    {31'd0, zero}, 32'd0);
    check("t2_ov1",   {31'd0, overflow}, 32'd0);
    req1 = 1'b0;

    // Lone requester 1 back-to-back, never starved
    do_reset();
    snap = done0_cnt;
    a1 = 16'd0; b1 = 16'd8; op1 = 3'b111; req1 = 1'b1;
    wait_done(1, n);
    check("t3_r_a", {16'd0, r}, 32'd1);
    wait_done(1, n);
    check("t3_gap_b", n, 32'd3);
    check("t3_r_b", {16'd0, r}, 32'd1);
    wait_done(1, n);
    check("t3_gap_c", n, 32'd3);
    check("t3_r_c", {16'd0, r}, 32'd1);
    req1 = 1'b0;
    @(posedge clk); #1;
    check("t3_no_done0", done0_cnt - snap, 32'd0);

    // Both held: grants alternate starting with port 0
    do_reset();
    a0 = 16'hFFFF; b0 = 16'h0000; op0 = 3'b000;
    a1 = 16'hFFFF; b1 = 16'h0000; op1 = 3'b000;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_any(w);
      check($sformatf("t4_who%0d", k), w, k % 2);
      check($sformatf("t4_r%0d", k), {16'd0, r}, 32'd0);
      check($sformatf("t4_z%0d", k), {31'd0, zero}, 32'd1);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // Illegal op reports err with cleared result, then a legal op clears err
    do_reset();
    a0 = 16'h1234; b0 = 16'h0F0F; op0 = 3'b011; req0 = 1'b1;
    wait_done(0, n);
    check("t5_err",   {31'd0, err}, 32'd1);
    check("t5_r",     {16'd0, r}, 32'd0);
    check("t5_flags", {29'd0, c_out, overflow, zero}, 32'd0);
    req0 = 1'b0;
    @(posedge clk); #1;
    a0 = 16'd5; b0 = 16'd0; op0 = 3'b010; req0 = 1'b1;
    wait_done(0, n);
    check("t5_err_clr", {31'd0, err}, 32'd0);
    check("t5_r2",      {16'd0, r}, 32'd5);
    req0 = 1'b0;
    @(posedge clk); #1;

    // Reset during EXEC of a port-1 op
    a1 = 16'd3; b1 = 16'd4; op1 = 3'b010; req1 = 1'b1;
    @(posedge clk); #1;
    check("t6_busy", {31'd0, busy}, 32'd1);
    snap = done1_cnt;
    #2 reset = 1'b1;
    #1;
    check("t6_async_r",    {16'd0, r}, 32'd0);
    check("t6_async_alu",  {16'd0, alu_a}, 32'd0);
    check("t6_async_busy", {31'd0, busy}, 32'd0);
    req1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_done1", done1_cnt - snap, 32'd0);
    req1 = 1'b1;
    wait_done(1, n);
    check("t6_rereq_r", {16'd0, r}, 32'd7);
    req1 = 1'b0;
    @(posedge clk); #1;

    check("never_both_done", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
